mem_arbiter: RTL

//  Two-port arbiter/sequencer for the single-port latch-based program/data memory of the MC14500B system.

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both requester ports and the memory-side signals.
//   slave  modport: arbiter view (requests and mem_data_out in; acks, read data,
//                   busy and memory strobes/address/data out).
//   master modport: requester/memory view (the mirror image).
// Parameters: WORD (data width), SIZE_LOG (address width).
interface mem_arbiter_if #(
    parameter int WORD     = 1,
    parameter int SIZE_LOG = 8
);
    logic                req0, req1;
    logic                we0, we1;
    logic [SIZE_LOG-1:0] addr0, addr1;
    logic [WORD-1:0]     wdata0, wdata1;
    logic                ack0, ack1;
    logic [WORD-1:0]     rdata0, rdata1;
    logic                busy;
    logic                mem_read, mem_write;
    logic [SIZE_LOG-1:0] mem_address;
    logic [WORD-1:0]     mem_data_in;
    logic [WORD-1:0]     mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_address, mem_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the single-port
// latch-based MC14500B program/data memory. Every access runs
// IDLE -> ACCESS -> ACK -> IDLE, so the memory sees a registered, glitch-free
// one-cycle read or write strobe with address/data held steady around it.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: req/we/addr/wdata/ack/rdata for ports 0 and 1,
//          busy, and mem_read/mem_write/mem_address/mem_data_in/mem_data_out.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin between simultaneous requesters (last_gnt register)
//   undefined - fixed priority, port 0 wins simultaneous requests
module mem_arbiter #(
    parameter int WORD     = 1,
    parameter int SIZE_LOG = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    logic [1:0]          state;
    logic                gnt;        // port owning the in-flight access
    logic                win1;       // port 1 wins arbitration this cycle
    logic                sel_we;
    logic [SIZE_LOG-1:0] sel_addr;
    logic [WORD-1:0]     sel_wdata;
`ifdef MEM_ARB_RR_EN
    logic                last_gnt;   // most recent winner
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // Port 1 wins alone, or on a tie when port 0 won last time.
        win1 = bus.req1 & (~bus.req0 | ~last_gnt);
`else
        win1 = bus.req1 & ~bus.req0;
`endif
        sel_we    = win1 ? bus.we1    : bus.we0;
        sel_addr  = win1 ? bus.addr1  : bus.addr0;
        sel_wdata = win1 ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            gnt             <= 1'b0;
            bus.ack0        <= 1'b0;
            bus.ack1        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.rdata0      <= '0;
            bus.rdata1      <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        // Address/data only move here, i.e. while strobes are low.
                        gnt             <= win1;
                        bus.mem_address <= sel_addr;
                        bus.mem_data_in <= sel_wdata;
                        bus.mem_read    <= ~sel_we;
                        bus.mem_write   <= sel_we;
                        bus.busy        <= 1'b1;
                        state           <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_gnt        <= win1;
`endif
                    end
                end
                ACCESS: begin
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    // mem_read still reflects the access kind during ACCESS.
                    if (bus.mem_read) begin
                        if (gnt) bus.rdata1 <= bus.mem_data_out;
                        else     bus.rdata0 <= bus.mem_data_out;
                    end
                    if (gnt) bus.ack1 <= 1'b1;
                    else     bus.ack0 <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.ack0      <= 1'b0;
                    bus.ack1      <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
